exe_muldiv: RTL and testbench

- Execute-stage RV32M unit, directly downstream of the ID/EXE pipeline register.
- Consumes the registered instruction and operands, then computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with an iterative datapath.
- Holds the pipeline through stall_req_o to ctrl until the result is ready.
- The result is muxed into the EXE writeback path alongside the ALU result.

---
 rtl/exe_muldiv_pkg.sv | 24 ++
 rtl/exe_muldiv_core.sv | 58 +++++
 rtl/exe_muldiv.sv | 120 ++++++++++++
 tb/tb_exe_muldiv.sv | 127 ++++++++++++
 4 files changed

// File: rtl/exe_muldiv_pkg.sv
// Shared RV32M decode constants and FSM encoding for the execute-stage mul/div unit.
package exe_muldiv_pkg;
  localparam logic [6:0]  INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0]  FUNCT7_M      = 7'b0000001;

  localparam logic [2:0]  INST_MUL      = 3'b000;
  localparam logic [2:0]  INST_MULH     = 3'b001;
  localparam logic [2:0]  INST_MULHSU   = 3'b010;
  localparam logic [2:0]  INST_MULHU    = 3'b011;
  localparam logic [2:0]  INST_DIV      = 3'b100;
  localparam logic [2:0]  INST_DIVU     = 3'b101;
  localparam logic [2:0]  INST_REM      = 3'b110;
  localparam logic [2:0]  INST_REMU     = 3'b111;

  localparam logic        STOP          = 1'b1;
  localparam logic        NOSTOP        = 1'b0;
  localparam logic [31:0] ZERO          = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/exe_muldiv_core.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide, one bit per cycle.
module muldiv_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] res
);
  logic              run;
  logic              div_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] nxt;
  logic [XLEN:0]     msum;
  logic [XLEN:0]     dtop;
  logic [XLEN:0]     ddiff;

  // acc holds {partial_hi, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    msum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    dtop  = acc[2*XLEN-1:XLEN-1];
    ddiff = dtop - {1'b0, opnd};
    nxt   = {msum, acc[XLEN-1:1]};
    if (div_q)
      nxt = ddiff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                        : {ddiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run   <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      opnd  <= '0;
      acc   <= '0;
    end else if (start) begin
      run   <= 1'b1;
      div_q <= is_div;
      cnt   <= '0;
      opnd  <= is_div ? b : a;
      acc   <= {{XLEN{1'b0}}, (is_div ? a : b)};
    end else if (run) begin
      acc <= nxt;
      cnt <= cnt + 1'b1;
      if (cnt == {CNT_W{1'b1}}) run <= 1'b0;
    end
  end

  assign done = run && (cnt == {CNT_W{1'b1}});
  assign res  = acc;
endmodule

// File: rtl/exe_muldiv.sv
// RV32M execute unit: decode, sign handling, fast cases and pipeline stall.
// Optional FAST_MUL_EN: single-cycle combinational multiply instead of the iterative path.
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            stall_req_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o
);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state;
  logic [2:0]        f3, f3_q;
  logic              is_m, is_div, sgn1, sgn2, n1, n2, neg, neg_q;
  logic              div0, ovf, fast, fast_q;
  logic [XLEN-1:0]   mag1, mag2, fast_val, fast_res_q;
  logic              start, core_done;
  logic [2*XLEN-1:0] core_res, mul_p;
  logic [XLEN-1:0]   dv;
  logic              unused;

  assign f3     = inst_i[14:12];
  assign is_m   = (inst_i[6:0] == INST_TYPE_R_M) && (inst_i[31:25] == FUNCT7_M);
  assign is_div = f3[2];
  assign sgn1   = !(f3 == INST_MULHU || f3 == INST_DIVU || f3 == INST_REMU);
  assign sgn2   = sgn1 && (f3 != INST_MULHSU);
  assign n1     = sgn1 && op1_i[XLEN-1];
  assign n2     = sgn2 && op2_i[XLEN-1];
  assign mag1   = n1 ? -op1_i : op1_i;
  assign mag2   = n2 ? -op2_i : op2_i;
  // remainder follows the dividend; every other signed op follows sign(op1)^sign(op2)
  assign neg    = (f3 == INST_REM) ? n1 : (n1 ^ n2);

  assign div0   = is_div && (op2_i == '0);
  assign ovf    = (f3 == INST_DIV || f3 == INST_REM) && (op1_i == SMIN) && (op2_i == '1);

`ifdef FAST_MUL_EN
  logic signed [2*XLEN+1:0] fprod;
  assign fprod  = $signed({n1, op1_i}) * $signed({n2, op2_i});
  assign fast   = is_div ? (div0 || ovf) : 1'b1;
  always_comb begin
    fast_val = '0;
    if (!is_div)   fast_val = (f3 == INST_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    else if (div0) fast_val = f3[1] ? op1_i : '1;
    else if (ovf)  fast_val = f3[1] ? '0 : SMIN;
  end
  assign unused = ^{inst_i[24:15], inst_i[11:7], fprod[2*XLEN+1:2*XLEN]};
`else
  assign fast   = div0 || ovf;
  always_comb begin
    fast_val = '0;
    if (div0)     fast_val = f3[1] ? op1_i : '1;
    else if (ovf) fast_val = f3[1] ? '0 : SMIN;
  end
  assign unused = ^{inst_i[24:15], inst_i[11:7]};
`endif

  assign start = (state == S_IDLE) && is_m && !fast;

  muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (start),
    .is_div (is_div),
    .a      (mag1),
    .b      (mag2),
    .done   (core_done),
    .res    (core_res)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      f3_q       <= '0;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (is_m) begin
          f3_q       <= f3;
          neg_q      <= neg;
          fast_q     <= fast;
          fast_res_q <= fast_val;
          state      <= fast ? S_DONE : S_BUSY;
        end
        S_BUSY: if (core_done) state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mul_p = neg_q ? -core_res : core_res;
  assign dv    = f3_q[1] ? core_res[2*XLEN-1:XLEN] : core_res[XLEN-1:0];

  always_comb begin
    result_o = '0;
    if (state == S_DONE) begin
      if (fast_q)               result_o = fast_res_q;
      else if (f3_q[2])         result_o = neg_q ? -dv : dv;
      else if (f3_q == INST_MUL) result_o = mul_p[XLEN-1:0];
      else                      result_o = mul_p[2*XLEN-1:XLEN];
    end
  end

  // gated by reset so a decoded M-op cannot raise stall while the unit is held
  assign stall_req_o    = (rst_i && ((state == S_IDLE && is_m) || state == S_BUSY)) ? STOP : NOSTOP;
  assign busy_o         = (state != S_IDLE);
  assign result_valid_o = (state == S_DONE);
endmodule

// File: tb/tb_exe_muldiv.sv
// Directed-vector bench for exe_muldiv: results, latency, stall, fast cases, back-to-back, reset abort.
module tb_exe_muldiv;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] inst_i, op1_i, op2_i;
  logic        stall_req_o, busy_o, result_valid_o;
  logic [31:0] result_o;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam logic [31:0] ADD_INST = 32'h002081B3;

  exe_muldiv dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .inst_i         (inst_i),
    .op1_i          (op1_i),
    .op2_i          (op2_i),
    .stall_req_o    (stall_req_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_inst(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // starts at posedge+1 (cycle 0), returns at posedge+1 of the cycle after the result
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc, stalls;
    cyc = 0; stalls = 0;
    inst_i = m_inst(f3); op1_i = a; op2_i = b;
    while (cyc < 40) begin
      @(negedge clk_i);
      if (result_valid_o) break;
      if (stall_req_o) stalls++;
      if (cyc == 1) begin op1_i = ~a; op2_i = ~b; end
      cyc++;
    end
    chk({tag, " valid"},  {31'b0, result_valid_o}, 32'd1);
    chk({tag, " lat"},    32'(cyc), 32'(lat));
    chk({tag, " stalls"}, 32'(stalls), 32'(lat));
    chk({tag, " res"},    result_o, exp);
    chk({tag, " dstall"}, {31'b0, stall_req_o}, 32'd0);
    @(posedge clk_i); #1;
  endtask

  task automatic idle_chk(input string tag);
    inst_i = ADD_INST; op1_i = 32'd9; op2_i = 32'd4;
    @(negedge clk_i);
    chk({tag, " stall"}, {31'b0, stall_req_o}, 32'd0);
    chk({tag, " busy"},  {31'b0, busy_o}, 32'd0);
    chk({tag, " valid"}, {31'b0, result_valid_o}, 32'd0);
    chk({tag, " res"},   result_o, 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    inst_i = m_inst(3'b100); op1_i = 32'd100; op2_i = 32'd7;
    #12;
    chk("rst stall", {31'b0, stall_req_o}, 32'd0);
    chk("rst busy",  {31'b0, busy_o}, 32'd0);
    chk("rst valid", {31'b0, result_valid_o}, 32'd0);
    chk("rst res",   result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    run_op("div",      3'b100, 32'd100,      32'd7,        32'd14,       33);
    run_op("rem",      3'b110, 32'd100,      32'd7,        32'd2,        33);
    run_op("rem neg",  3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33);
    run_op("div neg",  3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33);
    run_op("divu z",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu z",   3'b111, 32'd5,        32'd0,        32'd5,        1);
    run_op("div z",    3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1);
    run_op("div ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("mulh",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        MUL_LAT);
    run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
    run_op("mul 2^32", 3'b000, 32'h00010000, 32'h00010000, 32'd0,        MUL_LAT);
    run_op("mul neg",  3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);

    run_op("b2b mul",  3'b000, 32'd3,        32'd5,        32'd15,       MUL_LAT);
    run_op("b2b divu", 3'b101, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 33);
    idle_chk("b2b after");
    run_op("sep mul",  3'b000, 32'd6,        32'd7,        32'd42,       MUL_LAT);
    idle_chk("sep nonm");
    run_op("sep divu", 3'b101, 32'd50,       32'd8,        32'd6,        33);

    inst_i = m_inst(3'b100); op1_i = 32'd1000; op2_i = 32'd3;
    repeat (11) @(posedge clk_i);
    #1;
    chk("mid busy", {31'b0, busy_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("abort stall", {31'b0, stall_req_o}, 32'd0);
    chk("abort busy",  {31'b0, busy_o}, 32'd0);
    chk("abort valid", {31'b0, result_valid_o}, 32'd0);
    chk("abort res",   result_o, 32'd0);
    inst_i = ADD_INST;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    run_op("post rst", 3'b100, 32'd1000, 32'd3, 32'd333, 33);
    idle_chk("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
